// File: rtl/lfsr32_pkg.sv
// Shared LFSR32 definitions: feedback taps, the one-step advance function and
// the checker state encoding, used by both the pattern generator and checker.
package lfsr32_pkg;

  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] x,
                                              input logic [31:0] taps);
    return {x[30:0], ^(x & taps)};
  endfunction

endpackage

// File: rtl/lfsr32_checker.sv
// Receive-side LFSR32 checker: self-synchronises to the incoming word stream,
// then flywheels its own prediction and counts mismatched words.
module lfsr32_checker
  import lfsr32_pkg::*;
#(
  parameter logic [31:0] TAPS        = LFSR32_TAPS,
  parameter int          LOCK_CNT    = 4,
  parameter int          UNLOCK_ERRS = 3,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_num,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      expected
);

  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_ERRS) ? LOCK_CNT : UNLOCK_ERRS;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  chk_state_e       state_q, state_d;
  logic [RUN_W-1:0] match_q, match_d;
  logic [RUN_W-1:0] miss_q, miss_d;
  logic [31:0]      expected_d;
  logic             locked_d;
  logic             pulse_d;
  logic [CNT_W-1:0] count_d;
  logic             count_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      match_q   <= '0;
      miss_q    <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      expected  <= expected_d;
      locked    <= locked_d;
      err_pulse <= pulse_d;
      err_count <= count_d;
    end
  end

  // Once locked the prediction runs from its own history, so isolated input
  // corruption never reseeds the sequence.
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    miss_d     = miss_q;
    expected_d = expected;
    locked_d   = locked;
    pulse_d    = 1'b0;
    count_err  = 1'b0;
    count_d    = err_count;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_num != 32'd0) begin
            expected_d = lfsr32_next(in_num, TAPS);
            match_d    = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          expected_d = lfsr32_next(in_num, TAPS);
          if (in_num == expected) begin
            match_d = match_q + RUN_W'(1);
            if (match_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            match_d = '0;
            if (in_num == 32'd0) state_d = HUNT;
          end
        end
        LOCKED: begin
          expected_d = lfsr32_next(expected, TAPS);
          if (in_num == expected) begin
            miss_d = '0;
          end else begin
            pulse_d   = 1'b1;
            count_err = 1'b1;
            miss_d    = miss_q + RUN_W'(1);
            if (miss_q + RUN_W'(1) == RUN_W'(UNLOCK_ERRS)) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              match_d  = '0;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end

    // A clear coinciding with a counted error keeps that error.
    if (clr_cnt)
      count_d = count_err ? CNT_W'(1) : '0;
    else if (count_err && !(&err_count))
      count_d = err_count + CNT_W'(1);
  end

endmodule
